// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: LFSR-chosen mole lit for LIFE_CYCLES, GAP_CYCLES dark between moles.
// Optional macro WRONG_WHACK_MISS_EN: a rise on an unlit switch while a mole is up counts as a miss.
module mole_spawner #(
    parameter int          NUM_MOLES   = 18,
    parameter int          LIFE_CYCLES = 50_000_000,
    parameter int          GAP_CYCLES  = 25_000_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [NUM_MOLES-1:0] whacked,
    output logic [NUM_MOLES-1:0] led,
    output logic                 hit,
    output logic                 miss,
    output logic                 busy
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int LW = (LIFE_CYCLES > 1) ? $clog2(LIFE_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [LW-1:0] LIFE_LAST = LW'(LIFE_CYCLES - 1);
    localparam logic [NUM_MOLES-1:0] ONE_BIT = {{(NUM_MOLES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GAP  = 2'b01,
        UP   = 2'b10
    } state_t;

    // Galois form, taps x^16, x^14, x^13, x^11 mapped onto bits 15, 13, 12, 10.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [4:0] mole_index(input logic [4:0] r);
        if (int'(r) >= NUM_MOLES) begin
            return r - 5'(NUM_MOLES);
        end else begin
            return r;
        end
    endfunction

    state_t                 state_r, state_s;
    logic [GW-1:0]          gap_cnt_r, gap_cnt_s;
    logic [LW-1:0]          life_cnt_r, life_cnt_s;
    logic [15:0]            lfsr_r;
    logic [NUM_MOLES-1:0]   whacked_q_r;
    logic [NUM_MOLES-1:0]   led_r, led_s;
    logic                   hit_r, hit_s;
    logic                   miss_r, miss_s;
    logic                   busy_r, busy_s;
    logic [NUM_MOLES-1:0]   rise_s;
    logic [NUM_MOLES-1:0]   onehot_s;
    logic                   lit_rise_s;
    logic                   wrong_rise_s;

    assign rise_s       = whacked & ~whacked_q_r;
    assign onehot_s     = ONE_BIT << mole_index(lfsr_r[4:0]);
    assign lit_rise_s   = |(rise_s & led_r);
    assign wrong_rise_s = |(rise_s & ~led_r);

    assign led  = led_r;
    assign hit  = hit_r;
    assign miss = miss_r;
    assign busy = busy_r;

    // LFSR free-runs and the switch history register; ones at reset mask held-high switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r      <= LFSR_SEED;
            whacked_q_r <= {NUM_MOLES{1'b1}};
        end else begin
            lfsr_r      <= lfsr_step(lfsr_r);
            whacked_q_r <= whacked;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            gap_cnt_r  <= {GW{1'b0}};
            life_cnt_r <= {LW{1'b0}};
            led_r      <= {NUM_MOLES{1'b0}};
            hit_r      <= 1'b0;
            miss_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            gap_cnt_r  <= gap_cnt_s;
            life_cnt_r <= life_cnt_s;
            led_r      <= led_s;
            hit_r      <= hit_s;
            miss_r     <= miss_s;
            busy_r     <= busy_s;
        end
    end

    // Next-state and next-output logic; stop overrides everything else.
    always_comb begin
        state_s    = state_r;
        gap_cnt_s  = gap_cnt_r;
        life_cnt_s = life_cnt_r;
        led_s      = led_r;
        hit_s      = 1'b0;
        miss_s     = 1'b0;
        busy_s     = busy_r;
        if (stop) begin
            state_s    = IDLE;
            gap_cnt_s  = {GW{1'b0}};
            life_cnt_s = {LW{1'b0}};
            led_s      = {NUM_MOLES{1'b0}};
            busy_s     = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    led_s  = {NUM_MOLES{1'b0}};
                    busy_s = 1'b0;
                    if (start) begin
                        state_s   = GAP;
                        gap_cnt_s = {GW{1'b0}};
                        busy_s    = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                GAP: begin
                    busy_s = 1'b1;
                    led_s  = {NUM_MOLES{1'b0}};
                    if (gap_cnt_r == GAP_LAST) begin
                        led_s      = onehot_s;
                        life_cnt_s = {LW{1'b0}};
                        gap_cnt_s  = {GW{1'b0}};
                        state_s    = UP;
                    end else begin
                        gap_cnt_s = gap_cnt_r + GW'(1);
                    end
                end
                UP: begin
                    busy_s = 1'b1;
                    if (lit_rise_s) begin
                        hit_s     = 1'b1;
                        led_s     = {NUM_MOLES{1'b0}};
                        gap_cnt_s = {GW{1'b0}};
                        state_s   = GAP;
`ifdef WRONG_WHACK_MISS_EN
                    end else if (wrong_rise_s) begin
                        miss_s    = 1'b1;
                        led_s     = {NUM_MOLES{1'b0}};
                        gap_cnt_s = {GW{1'b0}};
                        state_s   = GAP;
`endif
                    end else if (life_cnt_r == LIFE_LAST) begin
                        miss_s    = 1'b1;
                        led_s     = {NUM_MOLES{1'b0}};
                        gap_cnt_s = {GW{1'b0}};
                        state_s   = GAP;
                    end else begin
                        life_cnt_s = life_cnt_r + LW'(1);
                    end
                end
                default: begin
                    state_s    = IDLE;
                    gap_cnt_s  = {GW{1'b0}};
                    life_cnt_s = {LW{1'b0}};
                    led_s      = {NUM_MOLES{1'b0}};
                    busy_s     = 1'b0;
                end
            endcase
        end
    end

`ifndef WRONG_WHACK_MISS_EN
    // Unlit-switch rises are deliberately ignored in this build.
    logic unused_wrong_s;
    assign unused_wrong_s = wrong_rise_s;
`endif

endmodule

// File: tb/tb_mole_spawner.sv
// Self-checking bench for mole_spawner: directed phases plus random whacks, checked against
// a timestamp-based game model (spawn/expiry cycle numbers rather than counters).
module tb_mole_spawner;

    localparam int N    = 18;
    localparam int LIFE = 8;
    localparam int GAPC = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [N-1:0] whacked = {N{1'b1}};
    logic [N-1:0] led;
    logic         hit, miss, busy;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int           cyc;
    bit           m_on;
    int           m_mole;
    int           m_spawn_at;
    int           m_expire_at;
    bit           m_hit, m_miss;
    logic [N-1:0] m_prev;
    logic [15:0]  m_lfsr;

    mole_spawner #(.NUM_MOLES(N), .LIFE_CYCLES(LIFE), .GAP_CYCLES(GAPC), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .whacked(whacked), .led(led), .hit(hit), .miss(miss), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_lfsr_next(input logic [15:0] v);
        logic [15:0] mask;
        int taps [4] = '{16, 14, 13, 11};
        mask = 16'h0000;
        foreach (taps[k]) mask = mask | (16'h0001 << (taps[k] - 1));
        return v[0] ? ((v >> 1) ^ mask) : (v >> 1);
    endfunction

    function automatic int model_index(input logic [15:0] v);
        int r;
        r = int'(v) % 32;
        return (r >= N) ? r - N : r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 1'b0; m_mole = -1; m_hit = 1'b0; m_miss = 1'b0;
        m_prev = {N{1'b1}}; m_lfsr = SEED;
    endtask

    task automatic model_update();
        logic [N-1:0] rises;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cyc++;
        rises = whacked & ~m_prev;
        m_hit = 1'b0; m_miss = 1'b0;
        if (stop) begin
            m_on = 1'b0; m_mole = -1;
        end else if (!m_on) begin
            if (start) begin
                m_on = 1'b1; m_mole = -1; m_spawn_at = cyc + GAPC;
            end
        end else if (m_mole < 0) begin
            if (cyc == m_spawn_at) begin
                m_mole = model_index(m_lfsr);
                m_expire_at = cyc + LIFE;
            end
        end else if (rises[m_mole]) begin
            m_hit = 1'b1; m_mole = -1; m_spawn_at = cyc + GAPC;
`ifdef WRONG_WHACK_MISS_EN
        end else if (rises != '0) begin
            m_miss = 1'b1; m_mole = -1; m_spawn_at = cyc + GAPC;
`endif
        end else if (cyc == m_expire_at) begin
            m_miss = 1'b1; m_mole = -1; m_spawn_at = cyc + GAPC;
        end
        m_prev = whacked;
        m_lfsr = model_lfsr_next(m_lfsr);
    endtask

    function automatic logic [N-1:0] exp_led();
        return (m_mole >= 0) ? (N'(1) << m_mole) : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("led", 32'(led), 32'(exp_led()));
        chk("hit", 32'(hit), 32'(m_hit));
        chk("miss", 32'(miss), 32'(m_miss));
        chk("busy", 32'(busy), 32'(m_on));
        chk("lfsr", 32'(dut.lfsr_r), 32'(m_lfsr));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_lit(input string tag);
        int budget;
        budget = 40;
        while (m_mole < 0 && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (m_mole < 0) begin
            failures++;
            $display("FAIL %s timeout waiting for mole", tag);
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        // Reset: outputs clear asynchronously before any edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_miss", 32'(miss), 32'd0);
        @(negedge clk);
        ticks(2);
        rst_n = 1'b1;
        chk("rst_lfsr", 32'(dut.lfsr_r), 32'(SEED));
        ticks(5);

        // Switches drop; start one game.
        whacked = '0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_lit("first_mole");

        // Hit the lit switch 3 cycles into UP, then next mole after the gap.
        ticks(2);
        whacked[m_mole] = 1'b1;
        tick();
        whacked = '0;
        wait_lit("after_hit");

        // No whack: expiry miss.
        ticks(LIFE + 1);
        wait_lit("after_miss");

        // Lit-bit rise on the expiry cycle: hit only.
        while (cyc < m_expire_at - 1) tick();
        whacked[m_mole] = 1'b1;
        tick();
        whacked = '0;
        wait_lit("after_late_hit");

        // Unlit switch rise while a mole is up.
        tick();
        whacked[(m_mole + 1) % N] = 1'b1;
        ticks(2);
        whacked = '0;
        ticks(LIFE + GAPC + 2);

        // Random play: whacks, starts, stops.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3, 0) == 0) whacked = N'($urandom);
            if (m_mole >= 0 && $urandom_range(5, 0) == 0) whacked[m_mole] = ~whacked[m_mole];
            start = ($urandom_range(11, 0) == 0);
            stop  = ($urandom_range(47, 0) == 0);
            tick();
        end
        start = 1'b0; stop = 1'b0; whacked = '0;
        tick();

        // Async reset mid-UP: led and busy drop before the next edge, no miss.
        if (!m_on) begin
            start = 1'b1; tick(); start = 1'b0;
        end
        wait_lit("pre_reset");
        ticks(2);
        #2 rst_n = 1'b0;
        #1;
        chk("midup_rst_led", 32'(led), 32'd0);
        chk("midup_rst_busy", 32'(busy), 32'd0);
        chk("midup_rst_miss", 32'(miss), 32'd0);
        model_reset();
        @(negedge clk);
        ticks(2);
        rst_n = 1'b1;
        ticks(LIFE + GAPC);

        // Stop mid-GAP: back to idle, no pulse.
        start = 1'b1; tick(); start = 1'b0;
        ticks(2);
        stop = 1'b1; tick(); stop = 1'b0;
        ticks(GAPC + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mole_spawner.md
MOLE_SPAWNER -- requirements
Module: mole_spawner

Interface
REQ-001 SHALL have parameter NUM_MOLES, default 18, number of mole positions (LED/switch pairs).
REQ-002 SHALL have parameter LIFE_CYCLES, default 50_000_000, clock cycles a mole stays lit.
REQ-003 SHALL have parameter GAP_CYCLES, default 25_000_000, dark cycles between moles.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, LFSR reset value; a value of zero is illegal.
REQ-005 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  begins a game when idle.
REQ-008 SHALL have port stop  input  1  ends the game.
REQ-009 SHALL have port whacked  input  NUM_MOLES  debounced switch levels, one per position.
REQ-010 SHALL have port led  output  NUM_MOLES  one-hot lit mole, or all zero; feeds the scoring/display stage.
REQ-011 SHALL have port hit  output  1  one-cycle pulse, correct whack.
REQ-012 SHALL have port miss  output  1  one-cycle pulse, mole expired or wrong whack.
REQ-013 SHALL have port busy  output  1  high while a game runs.

Function
REQ-014 SHALL run a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle after reset regardless of state.
REQ-015 SHALL derive the mole index as r=lfsr[4:0]; index = r-NUM_MOLES if r>=NUM_MOLES, else r; the index is always < NUM_MOLES.
REQ-016 SHALL register whacked into whacked_q each cycle; rise[i] = whacked[i] & ~whacked_q[i].
REQ-017 SHALL implement states IDLE, GAP, UP; all outputs are registered.
REQ-018 IDLE: led=0, busy=0; start=1 -> GAP with gap counter=0, busy=1 from the next edge.
REQ-019 GAP: counter increments each cycle; on the cycle it equals GAP_CYCLES-1, led loads one-hot(index), life counter clears, state -> UP.
REQ-020 UP: rise on the lit bit -> hit=1 for one cycle, led=0, state -> GAP, counter cleared.
REQ-021 UP: no hit and life counter = LIFE_CYCLES-1 -> miss=1 for one cycle, led=0, state -> GAP; led is high exactly LIFE_CYCLES cycles.
REQ-022 Correct-bit rise in the same cycle as expiry SHALL produce hit only, never miss.
REQ-023 Rises on any bit in IDLE or GAP SHALL be ignored; hit and miss are never both high.
REQ-024 stop=1 in any state SHALL force IDLE on the next edge, with led=0, busy=0 and no hit/miss pulse; stop has priority over start and over hit/expiry.
REQ-025 start while busy SHALL be ignored.
REQ-026 Counters SHALL be sized $clog2 of their parameter and SHALL never wrap; they are cleared on every state entry.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge, set state=IDLE, led=0, hit=0, miss=0, busy=0, counters=0, lfsr=LFSR_SEED, whacked_q=all ones.
REQ-028 whacked_q resetting to all ones SHALL suppress spurious rises from switches held high through reset.
REQ-029 Reset asserted mid-UP SHALL extinguish led with no miss pulse; the block remains in IDLE after release until start.

Configuration
REQ-030 Macro WRONG_WHACK_MISS_EN defined: in UP, a rise on any unlit bit with no rise on the lit bit SHALL give miss=1 for one cycle, led=0, state -> GAP.
REQ-031 Macro WRONG_WHACK_MISS_EN undefined: rises on unlit bits in UP SHALL be ignored and the mole stays lit.

Verification (LIFE_CYCLES=8, GAP_CYCLES=4, NUM_MOLES=18)
REQ-032 Reset, then release with all whacked=1 -> led=0, hit=0, miss=0, busy=0, lfsr=16'hACE1; no pulses while whacked stays high.
REQ-033 start pulse -> busy=1 next edge; led becomes one-hot 4 edges after entering GAP, with index <18 and equal to the bench LFSR model.
REQ-034 Raise the lit switch 3 cycles into UP -> hit high exactly 1 cycle, led=0; next mole lit 4 cycles later.
REQ-035 No whack -> led high for exactly 8 cycles, then miss for 1 cycle; lit-bit rise on the expiry cycle -> hit only.
REQ-036 Raise an unlit switch in UP -> macro undefined: no pulse, led unchanged; macro defined: miss 1 cycle, led=0.
REQ-037 rst_n low mid-UP -> led=0 and busy=0 before the next edge; stop mid-GAP -> IDLE with no pulse.
